snowbro2_video_timing: RTL
==========================

// Module: snowbro2_video_timing
// PURPOSE
//  Raster timing generator for the GP9001 video path. Advances horizontal and vertical
//  pixel counters on the 6.75 MHz pixel enable (CEN675) derived from CLK96 and produces
//  blanking, sync, a frame-start strobe and a latched vblank interrupt request for the
//  68000. It sits directly downstream of the clock-enable generator and feeds the
//  GP9001 renderer, the video output stage and the CPU interrupt logic.
// PARAMETERS
//  CW        9    counter width in bits for HCNT/VCNT
//  H_TOTAL   432  pixels per line; HCNT runs 0..H_TOTAL-1
//  H_ACTIVE  320  visible pixels; HBLANK=1 for HCNT>=H_ACTIVE
//  HS_START  352  first HCNT value with HSYNC=1
//  HS_END    384  first HCNT value after the HSYNC pulse, so 32 pixels wide
//  V_TOTAL   262  lines per frame; VCNT runs 0..V_TOTAL-1
//  V_ACTIVE  240  visible lines; VBLANK=1 for VCNT>=V_ACTIVE
//  VS_START  245  first VCNT value with VSYNC=1
//  VS_END    248  first VCNT value after the VSYNC pulse, so 3 lines wide
// PORTS
//  CLK96        in   1   96 MHz system clock; the only clock
//  RESET96_n    in   1   synchronous reset, active low
//  CEN675       in   1   pixel clock enable at 6.75 MHz, one CLK96 cycle wide
//  INT_ACK      in   1   CPU interrupt acknowledge, level, sampled every CLK96 cycle
//  HCNT         out  CW  horizontal pixel counter
//  VCNT         out  CW  vertical line counter
//  HBLANK       out  1   horizontal blank, active high
//  VBLANK       out  1   vertical blank, active high
//  HSYNC        out  1   horizontal sync, active high
//  VSYNC        out  1   vertical sync, active high
//  FRAME_START  out  1   strobe one CLK96 cycle wide when the counters wrap to (0,0)
//  VINT         out  1   vblank interrupt request, latched until acknowledged
// BEHAVIOUR
//  - All outputs are registered and update only on CLK96 edges where CEN675=1. VINT is
//    the exception: INT_ACK can clear it on any CLK96 edge.
//  - Reset values (RESET96_n=0 at a CLK96 edge): HCNT=0, VCNT=0, HBLANK=0, VBLANK=0,
//    HSYNC=0, VSYNC=0, FRAME_START=0, VINT=0. Reset overrides CEN675 and INT_ACK.
//  - Reset mid-frame restarts the raster at (0,0). No FRAME_START is issued for this
//    restart.
//  - Horizontal counting on CEN675: HCNT = (HCNT==H_TOTAL-1) ? 0 : HCNT+1.
//  - Vertical counting: VCNT advances only on the CEN675 cycle where HCNT wraps.
//    VCNT = (VCNT==V_TOTAL-1) ? 0 : VCNT+1.
//  - Decoded outputs are computed from the next counter values, so they align with
//    HCNT/VCNT in the same cycle with zero latency relative to the counters.
//  - HSYNC = HS_START<=HCNT<HS_END. VSYNC = VS_START<=VCNT<VS_END. VSYNC changes only
//    at line boundaries.
//  - FRAME_START is 1 for exactly the CLK96 cycle after the CEN675 edge that loads
//    (HCNT,VCNT)=(0,0) from (H_TOTAL-1,V_TOTAL-1). It is 0 on all other cycles,
//    including cycles where CEN675=0.
//  - VINT is set on the CEN675 edge that loads (HCNT,VCNT)=(0,V_ACTIVE), i.e. at vblank
//    entry. It stays 1 until a CLK96 edge with INT_ACK=1.
//  - Set and INT_ACK on the same edge: the set wins and VINT stays 1.
//  - INT_ACK held high through the set edge does not block the set. The next edge with
//    INT_ACK still high clears VINT.
//  - CEN675 held low freezes all counters and decoded outputs indefinitely.
//  - Counter arithmetic is unsigned, width CW. Parameters must satisfy
//    H_TOTAL<=2**CW and V_TOTAL<=2**CW; otherwise the module fails elaboration with
//    a $error.
// TESTING
//  1. Reset, then 431 CEN675 pulses -> HCNT=431, VCNT=0. Next pulse -> HCNT=0, VCNT=1.
//  2. Sweep one line -> HBLANK rises at HCNT=320 and HSYNC=1 for HCNT 352..383 only,
//     both aligned with HCNT.
//  3. Run 432*262 pulses from reset -> a single 1-cycle FRAME_START at (0,0).
//     VSYNC=1 for lines 245..247. Frame length is 113184 CEN675 pulses.
//  4. Reach (0,240) -> VBLANK=1 and VINT=1. INT_ACK pulse 5 CLK96 cycles later ->
//     VINT=0 on the next edge. Ack coincident with the set edge -> VINT remains 1.
//  5. Hold CEN675=0 for 1000 CLK96 cycles mid-line at HCNT=100 -> all outputs
//     unchanged and FRAME_START=0 throughout.
//  6. Assert RESET96_n=0 at (200,250) with VINT=1 -> next cycle all outputs at reset
//     values. Raster then restarts cleanly with no spurious FRAME_START.

Source files
------------

// File: rtl/snowbro2_video_timing_if.sv
// snowbro2_video_timing_if: pixel-enable/ack inputs and decoded raster outputs
interface snowbro2_video_timing_if #(parameter int CW = 9);
  logic          CEN675;
  logic          INT_ACK;
  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic          HBLANK;
  logic          VBLANK;
  logic          HSYNC;
  logic          VSYNC;
  logic          FRAME_START;
  logic          VINT;
  modport master (
    output CEN675, INT_ACK,
    input  HCNT, VCNT, HBLANK, VBLANK, HSYNC, VSYNC, FRAME_START, VINT
  );
  modport slave (
    input  CEN675, INT_ACK,
    output HCNT, VCNT, HBLANK, VBLANK, HSYNC, VSYNC, FRAME_START, VINT
  );
endinterface

// File: rtl/snowbro2_video_timing.sv
// snowbro2_video_timing: GP9001 raster counters, blank/sync decode, frame strobe and vblank IRQ
module snowbro2_video_timing #(
  parameter int CW       = 9,
  parameter int H_TOTAL  = 432,
  parameter int H_ACTIVE = 320,
  parameter int HS_START = 352,
  parameter int HS_END   = 384,
  parameter int V_TOTAL  = 262,
  parameter int V_ACTIVE = 240,
  parameter int VS_START = 245,
  parameter int VS_END   = 248
) (
  input  logic                    CLK96,
  input  logic                    RESET96_n,
  snowbro2_video_timing_if.slave  vt
);
  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_params
    $error("snowbro2_video_timing: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW:0]   h_ext, v_ext;
  logic          h_wrap, v_wrap, vint_set;
  logic          hblank_q, hblank_d, vblank_q, vblank_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d, vint_q, vint_d;
  // Next counters; decodes use the next values so they line up with HCNT/VCNT
  always_comb begin
    h_wrap        = hcnt_q == CW'(H_TOTAL - 1);
    v_wrap        = vcnt_q == CW'(V_TOTAL - 1);
    hcnt_d        = !vt.CEN675 ? hcnt_q : h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d        = !(vt.CEN675 && h_wrap) ? vcnt_q : v_wrap ? '0 : vcnt_q + 1'b1;
    h_ext         = {1'b0, hcnt_d};
    v_ext         = {1'b0, vcnt_d};
    hblank_d      = h_ext >= (CW+1)'(H_ACTIVE);
    vblank_d      = v_ext >= (CW+1)'(V_ACTIVE);
    hsync_d       = h_ext >= (CW+1)'(HS_START) && h_ext < (CW+1)'(HS_END);
    vsync_d       = v_ext >= (CW+1)'(VS_START) && v_ext < (CW+1)'(VS_END);
    frame_start_d = vt.CEN675 && h_wrap && v_wrap;
    vint_set      = vt.CEN675 && h_wrap && v_ext == (CW+1)'(V_ACTIVE);
    vint_d        = vint_set ? 1'b1 : vt.INT_ACK ? 1'b0 : vint_q;
  end
  // State register; reset restarts the raster without a frame strobe
  always_ff @(posedge CLK96) begin
    if (!RESET96_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      vint_q        <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      vint_q        <= vint_d;
    end
  end
  assign vt.HCNT        = hcnt_q;
  assign vt.VCNT        = vcnt_q;
  assign vt.HBLANK      = hblank_q;
  assign vt.VBLANK      = vblank_q;
  assign vt.HSYNC       = hsync_q;
  assign vt.VSYNC       = vsync_q;
  assign vt.FRAME_START = frame_start_q;
  assign vt.VINT        = vint_q;
endmodule
